// File: rtl/sl_pkg.sv
// Shared SL link types and helpers used by the transmitter and the SL receiver.
package sl_pkg;

  localparam int unsigned SL_DATA_W = 32;
  localparam int unsigned SL_CNT_W  = 6;

  typedef logic [SL_CNT_W-1:0]  sl_cnt_t;
  typedef logic [SL_DATA_W-1:0] sl_word_t;

  typedef enum logic [1:0] {
    SL_M8   = 2'd0,
    SL_M16  = 2'd1,
    SL_M32  = 2'd2,
    SL_MBAD = 2'd3
  } sl_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BIT_LOW   = 3'd1,
    ST_BIT_HIGH  = 3'd2,
    ST_PAR_LOW   = 3'd3,
    ST_PAR_HIGH  = 3'd4,
    ST_STOP_LOW  = 3'd5,
    ST_STOP_HIGH = 3'd6
  } sl_tx_state_t;

  // Data bits per frame; 0 flags the illegal mode.
  function automatic sl_cnt_t sl_nbits(input sl_mode_t mode);
    case (mode)
      SL_M8:   return sl_cnt_t'(8);
      SL_M16:  return sl_cnt_t'(16);
      SL_M32:  return sl_cnt_t'(32);
      default: return sl_cnt_t'(0);
    endcase
  endfunction

  // Odd parity over the active low bits; masked-off bits do not change the XOR.
  function automatic logic sl_parity(input sl_word_t data, input sl_mode_t mode);
    sl_word_t mask;
    case (mode)
      SL_M8:   mask = 32'h0000_00FF;
      SL_M16:  mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return ~^(data & mask);
  endfunction

endpackage

// File: rtl/sl_transmitter_if.sv
// Word-request handshake plus the two SL link lines driven by the transmitter.
interface sl_transmitter_if;
  import sl_pkg::*;

  logic [1:0]  mode;
  sl_word_t    data;
  logic        start;
  logic        ready;
  logic        done;
  logic        err;
  logic        sl0;
  logic        sl1;

  modport master (
    output mode, data, start,
    input  ready, done, err, sl0, sl1
  );

  modport slave (
    input  mode, data, start,
    output ready, done, err, sl0, sl1
  );
endinterface

// File: rtl/sl_phase_timer.sv
// Loadable down-counter that times each line phase; holds at zero.
module sl_phase_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  output logic          o_tc_c
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TW'(1);
    end
  end

  assign o_tc_c = (r_cnt == '0);

endmodule

// File: rtl/sl_transmitter.sv
// Serialises a latched word onto the two-wire SL link: N data bits LSB first,
// an odd-parity bit, then a stop symbol with both lines low together.
module sl_transmitter
  import sl_pkg::*;
#(
  parameter int unsigned LOW_CYCLES  = 2,
  parameter int unsigned HIGH_CYCLES = 2,
  parameter int unsigned TW          = 8
) (
  input  logic               clk,
  input  logic               reset,
  sl_transmitter_if.slave    bus
);

  localparam logic [TW-1:0] LOW_LD  = TW'(LOW_CYCLES - 1);
  localparam logic [TW-1:0] HIGH_LD = TW'(HIGH_CYCLES - 1);

  sl_tx_state_t r_state;
  sl_word_t     r_shift;
  sl_cnt_t      r_bitcnt;
  sl_mode_t     r_mode;
  logic         r_par;
  logic         r_sl0;
  logic         r_sl1;
  logic         r_ready;
  logic         r_done;
  logic         r_err;

  sl_tx_state_t w_state_nxt;
  sl_word_t     w_shift_nxt;
  sl_cnt_t      w_bitcnt_nxt;
  sl_cnt_t      w_last_bit;
  sl_mode_t     w_mode_in;
  logic         w_accept;
  logic         w_done_nxt;
  logic         w_err_nxt;
  logic         w_sl0_nxt;
  logic         w_sl1_nxt;
  logic         w_load;
  logic [TW-1:0] w_load_val;
  logic         w_tc;

  assign w_mode_in  = sl_mode_t'(bus.mode);
  assign w_last_bit = sl_nbits(r_mode) - sl_cnt_t'(1);

  sl_phase_timer #(.TW(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc_c     (w_tc)
  );

  // State register and registered line/handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_mode   <= SL_M8;
      r_par    <= 1'b0;
      r_sl0    <= 1'b1;
      r_sl1    <= 1'b1;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      if (w_accept) begin
        r_mode <= w_mode_in;
        r_par  <= sl_parity(bus.data, w_mode_in);
      end
      r_sl0    <= w_sl0_nxt;
      r_sl1    <= w_sl1_nxt;
      r_ready  <= (w_state_nxt == ST_IDLE);
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Next-state, shifter, timer reload and next line levels.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_accept     = 1'b0;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_sl0_nxt    = 1'b1;
    w_sl1_nxt    = 1'b1;
    w_load       = 1'b0;
    w_load_val   = HIGH_LD;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (w_mode_in == SL_MBAD) begin
            w_err_nxt = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_state_nxt  = ST_BIT_LOW;
            w_shift_nxt  = bus.data;
            w_bitcnt_nxt = '0;
          end
        end
      end
      ST_BIT_LOW: begin
        if (w_tc) w_state_nxt = ST_BIT_HIGH;
      end
      ST_BIT_HIGH: begin
        if (w_tc) begin
          if (r_bitcnt == w_last_bit) begin
            w_state_nxt = ST_PAR_LOW;
          end else begin
            w_state_nxt  = ST_BIT_LOW;
            w_bitcnt_nxt = r_bitcnt + sl_cnt_t'(1);
            w_shift_nxt  = {1'b0, r_shift[SL_DATA_W-1:1]};
          end
        end
      end
      ST_PAR_LOW: begin
        if (w_tc) w_state_nxt = ST_PAR_HIGH;
      end
      ST_PAR_HIGH: begin
        if (w_tc) w_state_nxt = ST_STOP_LOW;
      end
      ST_STOP_LOW: begin
        if (w_tc) w_state_nxt = ST_STOP_HIGH;
      end
      ST_STOP_HIGH: begin
        if (w_tc) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Timer restarts on every state entry, including BIT_HIGH -> BIT_LOW.
    w_load = (w_state_nxt != r_state);
    if ((w_state_nxt == ST_BIT_LOW) || (w_state_nxt == ST_PAR_LOW) ||
        (w_state_nxt == ST_STOP_LOW)) begin
      w_load_val = LOW_LD;
    end

    // Lines follow the next state so they change on the same edge as r_state.
    case (w_state_nxt)
      ST_BIT_LOW: begin
        if (w_shift_nxt[0]) w_sl1_nxt = 1'b0;
        else                w_sl0_nxt = 1'b0;
      end
      ST_PAR_LOW: begin
        if (r_par) w_sl1_nxt = 1'b0;
        else       w_sl0_nxt = 1'b0;
      end
      ST_STOP_LOW: begin
        w_sl0_nxt = 1'b0;
        w_sl1_nxt = 1'b0;
      end
      default: begin
        w_sl0_nxt = 1'b1;
        w_sl1_nxt = 1'b1;
      end
    endcase
  end

  assign bus.ready = r_ready;
  assign bus.done  = r_done;
  assign bus.err   = r_err;
  assign bus.sl0   = r_sl0;
  assign bus.sl1   = r_sl1;

endmodule

// File: tb/tb_sl_transmitter.sv
// Scoreboard bench: stimulus pushes expected symbols/done/err times, a line monitor pops and checks.
module tb_sl_transmitter;

  localparam int LOW  = 2;
  localparam int HIGH = 2;

  logic clk;
  logic reset;
  sl_transmitter_if bus();

  sl_transmitter #(.LOW_CYCLES(LOW), .HIGH_CYCLES(HIGH), .TW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  longint ncyc = 0;

  int     exp_sym[$];
  longint exp_done[$];
  longint exp_err[$];

  always @(posedge clk) ncyc = ncyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d at cycle %0d", name, act, exp, ncyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: event with nothing expected at cycle %0d", name, ncyc);
  endtask

  // Expected symbols: data bits LSB first, hand-supplied parity, then stop (2).
  task automatic push_frame(input logic [31:0] d, input int nb, input int par, input longint t_done);
    logic [31:0] w;
    w = d;
    for (int i = 0; i < nb; i++) exp_sym.push_back(int'(w[i]));
    exp_sym.push_back(par);
    exp_sym.push_back(2);
    exp_done.push_back(t_done);
  endtask

  task automatic send(input logic [1:0] m, input logic [31:0] d, input int nb, input int par,
                      input int lat, input bit hold, output longint t_acc);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", bus.ready, 1);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.data  = d;
    t_acc = ncyc;
    push_frame(d, nb, par, ncyc + lat + 1);
    @(negedge clk);
    chk("ready_drop", bus.ready, 0);
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_sym.size() != 0 || exp_done.size() != 0 || exp_err.size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", longint'(exp_sym.size() + exp_done.size() + exp_err.size()), 0);
  endtask

  // Line monitor: decodes each low pulse, checks symbol, pulse and gap lengths.
  bit     in_low = 0;
  bit     have_prev = 0;
  int     prev_sym = 0;
  int     low_len = 0;
  int     hi_len = 0;
  logic [1:0] cur_pat = 2'b11;

  always @(negedge clk) begin
    logic [1:0] pat;
    int sym;
    if (reset) begin
      in_low    = 0;
      have_prev = 0;
    end else begin
      pat = {bus.sl1, bus.sl0};
      if (pat == 2'b11) begin
        if (in_low) begin
          chk("low_len", low_len, LOW);
          in_low = 0;
          hi_len = 0;
        end
        hi_len++;
      end else if (!in_low) begin
        sym = (pat == 2'b00) ? 2 : ((pat == 2'b01) ? 1 : 0);
        if (have_prev && prev_sym != 2) chk("high_len", hi_len, HIGH);
        if (exp_sym.size() == 0) fail_now("symbol_unexpected");
        else chk("symbol", sym, exp_sym.pop_front());
        in_low    = 1;
        low_len   = 1;
        cur_pat   = pat;
        prev_sym  = sym;
        have_prev = 1;
      end else begin
        if (pat != cur_pat) chk("pattern_stable", pat, cur_pat);
        low_len++;
      end
      if (bus.done) begin
        if (exp_done.size() == 0) fail_now("done_unexpected");
        else chk("done_cycle", ncyc, exp_done.pop_front());
        chk("ready_at_done", bus.ready, 1);
      end
      if (bus.err) begin
        if (exp_err.size() == 0) fail_now("err_unexpected");
        else chk("err_cycle", ncyc, exp_err.pop_front());
        chk("ready_at_err", bus.ready, 1);
      end
    end
  end

  initial begin
    longint t_acc;
    int t;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    bus.data  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_sl0", bus.sl0, 1);
    chk("rst_sl1", bus.sl1, 1);
    chk("rst_ready", bus.ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    reset = 1'b0;

    // 8/16/32-bit frames: 0xA5 -> P=1 (40), 0x1 -> P=0 (72), all ones -> P=1 (136)
    send(2'd0, 32'h0000_00A5, 8, 1, 40, 1'b0, t_acc);
    drain();
    send(2'd1, 32'h0000_0001, 16, 0, 72, 1'b0, t_acc);
    drain();
    send(2'd2, 32'hFFFF_FFFF, 32, 1, 136, 1'b0, t_acc);
    drain();

    // Illegal mode: err pulse only, then a normal frame (0x3C -> P=1).
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 2'd3;
    exp_err.push_back(ncyc + 1);
    @(negedge clk);
    bus.start = 1'b0;
    chk("bad_ready_stays", bus.ready, 1);
    chk("bad_sl0_high", bus.sl0, 1);
    chk("bad_sl1_high", bus.sl1, 1);
    send(2'd0, 32'h0000_003C, 8, 1, 40, 1'b0, t_acc);
    drain();

    // start mid-frame with new data/mode is ignored (0x81 -> P=1).
    send(2'd0, 32'h0000_0081, 8, 1, 40, 1'b0, t_acc);
    repeat (8) @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 2'd1;
    bus.data  = 32'h0000_FFFF;
    repeat (5) @(negedge clk);
    bus.start = 1'b0;
    drain();

    // Back-to-back: 0x5A (P=1) then 0x01 (P=0) accepted in the done cycle.
    send(2'd0, 32'h0000_005A, 8, 1, 40, 1'b1, t_acc);
    bus.mode = 2'd0;
    bus.data = 32'h0000_0001;
    t = 0;
    while (!bus.done && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("b2b_done_seen", bus.done, 1);
    push_frame(32'h0000_0001, 8, 0, ncyc + 40 + 1);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_first_sl1_low", bus.sl1, 0);
    chk("b2b_first_sl0_high", bus.sl0, 1);
    chk("b2b_ready_low", bus.ready, 0);
    drain();

    // Reset during parity low phase of 0xA5 (P=1 on sl1).
    send(2'd0, 32'h0000_00A5, 8, 1, 40, 1'b0, t_acc);
    t = 0;
    while (ncyc < t_acc + 33 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("par_phase_sl1_low", bus.sl1, 0);
    chk("par_phase_sl0_high", bus.sl0, 1);
    #2;
    reset = 1'b1;
    exp_sym.delete();
    exp_done.delete();
    #1;
    chk("rst_mid_sl0", bus.sl0, 1);
    chk("rst_mid_sl1", bus.sl1, 1);
    chk("rst_mid_ready", bus.ready, 1);
    chk("rst_mid_done", bus.done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    send(2'd0, 32'h0000_000F, 8, 1, 40, 1'b0, t_acc);
    drain();

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
